byte_mem_wait: RTL and testbench

//  Word-organised on-chip memory with byte-masked writes and configurable wait states.

---
 rtl/byte_mem_wait_if.sv | 32 +++
 rtl/byte_mem_wait.sv | 148 ++++++++++++++
 tb/tb_byte_mem_wait.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_mem_wait_if.sv
// ============================================================================
//  Module      : byte_mem_wait_if
//  Description : Request/response bus between the byte-interface mux (master)
//                and the wait-state word memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface byte_mem_wait_if #(
  parameter int DATA_BYTE = 4,
  parameter int ADDR_SIZE = 32
);
  logic                   memEnable_i;
  logic                   memIsWrite_i;
  logic [DATA_BYTE-1:0]   memWriteMask_i;
  logic [ADDR_SIZE-1:0]   memAddr_i;
  logic [DATA_BYTE*8-1:0] memWriteData_i;
  logic [DATA_BYTE*8-1:0] memReadData_o;
  logic                   memHold_o;

  modport master (
    output memEnable_i, memIsWrite_i, memWriteMask_i, memAddr_i, memWriteData_i,
    input  memReadData_o, memHold_o
  );

  modport slave (
    input  memEnable_i, memIsWrite_i, memWriteMask_i, memAddr_i, memWriteData_i,
    output memReadData_o, memHold_o
  );
endinterface

`default_nettype wire

// File: rtl/byte_mem_wait.sv
// ============================================================================
//  Module      : byte_mem_wait
//  Description : Word memory with byte-masked writes, registered reads and a
//                configurable number of wait states per access.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_mem_wait #(
  parameter int DATA_BYTE   = 4,
  parameter int ADDR_SIZE   = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  wire logic              clk_i,
  input  wire logic              rst_ni,
  byte_mem_wait_if.slave         bus,
  input  wire logic              errClear_i,
  output logic                   errAddr_o
);

  localparam int c_DW  = DATA_BYTE * 8;
  localparam int c_OFF = $clog2(DATA_BYTE);
  localparam int c_IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [c_CW-1:0]    c_RELOAD = c_CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [ADDR_SIZE:0] c_DEPTH  = (ADDR_SIZE + 1)'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                r_state, w_state_nx;
  logic [c_CW-1:0]       r_cnt, w_cnt_nx;
  logic [ADDR_SIZE-1:0]  r_tag_addr, w_tag_addr_nx;
  logic                  r_tag_wr, w_tag_wr_nx;
  logic                  w_hold;
  logic                  w_accept;
  logic                  w_tag_hit;

  logic [ADDR_SIZE-1:0]  w_word;
  logic [c_IW-1:0]       w_idx;
  logic                  w_in_range;

  logic [c_DW-1:0]       r_mem [DEPTH];
  logic [c_DW-1:0]       r_rdata;
  logic                  r_err;

  assign w_word     = bus.memAddr_i >> c_OFF;
  assign w_idx      = w_word[c_IW-1:0];
  assign w_in_range = ({1'b0, w_word} < c_DEPTH);
  assign w_tag_hit  = (bus.memAddr_i == r_tag_addr) && (bus.memIsWrite_i == r_tag_wr);

  assign bus.memHold_o     = w_hold;
  assign bus.memReadData_o = r_rdata;
  assign errAddr_o         = r_err;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_tag_addr <= '0;
      r_tag_wr   <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_tag_addr <= w_tag_addr_nx;
      r_tag_wr   <= w_tag_wr_nx;
    end
  end

  // A changed address or direction while waiting means upstream switched
  // requester, so the wait restarts for the new request.
  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_tag_addr_nx = r_tag_addr;
    w_tag_wr_nx   = r_tag_wr;
    w_hold        = 1'b0;
    w_accept      = 1'b0;
    if (!rst_ni) begin
      w_hold = bus.memEnable_i;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (WAIT_STATES == 0) begin
            w_accept = bus.memEnable_i;
          end else if (bus.memEnable_i) begin
            w_hold        = 1'b1;
            w_cnt_nx      = c_RELOAD;
            w_tag_addr_nx = bus.memAddr_i;
            w_tag_wr_nx   = bus.memIsWrite_i;
            w_state_nx    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (!bus.memEnable_i) begin
            w_state_nx = S_IDLE;
          end else if (!w_tag_hit) begin
            w_hold        = 1'b1;
            w_cnt_nx      = c_RELOAD;
            w_tag_addr_nx = bus.memAddr_i;
            w_tag_wr_nx   = bus.memIsWrite_i;
          end else if (r_cnt != '0) begin
            w_hold   = 1'b1;
            w_cnt_nx = r_cnt - c_CW'(1);
          end else begin
            w_accept   = 1'b1;
            w_state_nx = S_IDLE;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept && bus.memIsWrite_i && w_in_range) begin
      for (int b = 0; b < DATA_BYTE; b++) begin
        if (bus.memWriteMask_i[b]) begin
          r_mem[w_idx][8*b +: 8] <= bus.memWriteData_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rdata <= '0;
    end else if (w_accept && !bus.memIsWrite_i) begin
      r_rdata <= w_in_range ? r_mem[w_idx] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_accept && !w_in_range) begin
      r_err <= 1'b1;
    end else if (errClear_i) begin
      r_err <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_byte_mem_wait.sv
// ============================================================================
//  Module      : tb_byte_mem_wait
//  Description : Bench for byte_mem_wait with zero and three wait states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_byte_mem_wait;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic clr0, clr3;
  logic err0, err3;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk_i = ~clk_i;

  byte_mem_wait_if #(.DATA_BYTE(4), .ADDR_SIZE(32)) b0 ();
  byte_mem_wait_if #(.DATA_BYTE(4), .ADDR_SIZE(32)) b3 ();

  byte_mem_wait #(.DATA_BYTE(4), .ADDR_SIZE(32), .DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(b0.slave), .errClear_i(clr0), .errAddr_o(err0));

  byte_mem_wait #(.DATA_BYTE(4), .ADDR_SIZE(32), .DEPTH(256), .WAIT_STATES(3)) dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(b3.slave), .errClear_i(clr3), .errAddr_o(err3));

  typedef struct {
    bit          en;
    bit          wr;
    bit          clr;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_hold;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t tbl[$];

  // Reference state for the three-wait-state instance: 16 words in use.
  logic [31:0] m3 [16];
  logic [31:0] mrd;
  bit          merr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit en, bit wr, bit clr, logic [3:0] mask, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] erd, bit eerr);
    vec_t v;
    v.en = en; v.wr = wr; v.clr = clr; v.mask = mask; v.addr = addr; v.wdata = wdata;
    v.exp_hold = 1'b0; v.exp_rdata = erd; v.exp_err = eerr;
    return v;
  endfunction

  // Called at a negedge with the request already driven; returns at the
  // negedge following the accept edge with the request still driven.
  task automatic wait_accept(output int holds);
    holds = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!b3.memHold_o) break;
      holds++;
      @(negedge clk_i);
    end
    @(negedge clk_i);
  endtask

  task automatic access3(input bit wr, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, output int holds);
    b3.memEnable_i = 1'b1; b3.memIsWrite_i = wr; b3.memAddr_i = addr;
    b3.memWriteMask_i = mask; b3.memWriteData_i = data;
    wait_accept(holds);
    b3.memEnable_i = 1'b0;
  endtask

  task automatic model3(input bit wr, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data);
    int w;
    w = int'(addr >> 2);
    if (w >= 256) begin
      merr = 1'b1;
      if (!wr) mrd = 32'h0;
    end else if (wr) begin
      for (int b = 0; b < 4; b++)
        if (mask[b]) m3[w][8*b +: 8] = data[8*b +: 8];
    end else begin
      mrd = m3[w];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int h;
    logic [31:0] a, d;
    logic [3:0]  mk4;
    bit          wr;

    rst_ni = 1'b0; clr0 = 1'b0; clr3 = 1'b0;
    b0.memEnable_i = 1'b0; b0.memIsWrite_i = 1'b0; b0.memWriteMask_i = '0;
    b0.memAddr_i = '0; b0.memWriteData_i = '0;
    b3.memEnable_i = 1'b0; b3.memIsWrite_i = 1'b0; b3.memWriteMask_i = '0;
    b3.memAddr_i = '0; b3.memWriteData_i = '0;
    repeat (3) @(negedge clk_i);

    // In reset the hold output follows enable and nothing is accepted.
    b3.memEnable_i = 1'b1; b0.memEnable_i = 1'b1;
    #1 chk("rst hold3 en", b3.memHold_o, 1'b1);
    chk("rst hold0 en", b0.memHold_o, 1'b1);
    @(negedge clk_i);
    b3.memEnable_i = 1'b0; b0.memEnable_i = 1'b0;
    #1 chk("rst hold3 idle", b3.memHold_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("rst rdata0", b0.memReadData_o, 32'h0);
    chk("rst err0", err0, 1'b0);
    chk("rst rdata3", b3.memReadData_o, 32'h0);
    chk("rst err3", err3, 1'b0);
    @(negedge clk_i);

    // Zero-wait-state instance, one vector per clock.
    tbl.push_back(mk(1, 1, 0, 4'hF, 32'h10,  32'hDEADBEEF, 32'h0,        0));
    tbl.push_back(mk(1, 0, 0, 4'h0, 32'h10,  32'h0,        32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 1, 0, 4'h5, 32'h10,  32'h11223344, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 0, 0, 4'h0, 32'h13,  32'h0,        32'hDE22BE44, 0));
    tbl.push_back(mk(0, 0, 0, 4'h0, 32'h0,   32'h0,        32'hDE22BE44, 0));
    tbl.push_back(mk(1, 1, 0, 4'hF, 32'h0,   32'h12345678, 32'hDE22BE44, 0));
    tbl.push_back(mk(1, 1, 0, 4'hF, 32'h3FC, 32'hA5A5A5A5, 32'hDE22BE44, 0));
    tbl.push_back(mk(1, 1, 0, 4'hF, 32'h400, 32'hFFFFFFFF, 32'hDE22BE44, 1));
    tbl.push_back(mk(1, 0, 0, 4'h0, 32'h0,   32'h0,        32'h12345678, 1));
    tbl.push_back(mk(1, 0, 0, 4'h0, 32'h3FC, 32'h0,        32'hA5A5A5A5, 1));
    tbl.push_back(mk(1, 0, 0, 4'h0, 32'h400, 32'h0,        32'h0,        1));
    tbl.push_back(mk(0, 0, 1, 4'h0, 32'h0,   32'h0,        32'h0,        0));
    tbl.push_back(mk(1, 0, 1, 4'h0, 32'h404, 32'h0,        32'h0,        1));
    tbl.push_back(mk(0, 0, 1, 4'h0, 32'h0,   32'h0,        32'h0,        0));
    tbl.push_back(mk(1, 0, 0, 4'h0, 32'h11,  32'h0,        32'hDE22BE44, 0));

    foreach (tbl[i]) begin
      b0.memEnable_i = tbl[i].en; b0.memIsWrite_i = tbl[i].wr;
      b0.memWriteMask_i = tbl[i].mask; b0.memAddr_i = tbl[i].addr;
      b0.memWriteData_i = tbl[i].wdata; clr0 = tbl[i].clr;
      #1 chk($sformatf("v%0d hold", i), b0.memHold_o, tbl[i].exp_hold);
      @(posedge clk_i); #1;
      chk($sformatf("v%0d rdata", i), b0.memReadData_o, tbl[i].exp_rdata);
      chk($sformatf("v%0d err", i), err0, tbl[i].exp_err);
      @(negedge clk_i);
    end
    b0.memEnable_i = 1'b0; clr0 = 1'b0;

    // Three wait states: plain write then read.
    access3(1'b1, 32'h10, 4'hF, 32'h0BADF00D, h);
    chk("t3 wr holds", h, 3);
    access3(1'b0, 32'h10, 4'h0, 32'h0, h);
    chk("t3 rd holds", h, 3);
    chk("t3 rd data", b3.memReadData_o, 32'h0BADF00D);

    // Abandoned after two hold cycles: no write, next request waits again.
    b3.memEnable_i = 1'b1; b3.memIsWrite_i = 1'b1; b3.memAddr_i = 32'h10;
    b3.memWriteMask_i = 4'hF; b3.memWriteData_i = 32'h77777777;
    #1 chk("t3 ab hold1", b3.memHold_o, 1'b1);
    @(negedge clk_i);
    #1 chk("t3 ab hold2", b3.memHold_o, 1'b1);
    @(negedge clk_i);
    b3.memEnable_i = 1'b0;
    #1 chk("t3 ab drop", b3.memHold_o, 1'b0);
    @(negedge clk_i);
    access3(1'b0, 32'h10, 4'h0, 32'h0, h);
    chk("t3 ab holds", h, 3);
    chk("t3 ab data", b3.memReadData_o, 32'h0BADF00D);

    // Address switch during the wait restarts it for the new address.
    b3.memEnable_i = 1'b1; b3.memIsWrite_i = 1'b1; b3.memAddr_i = 32'h10;
    b3.memWriteMask_i = 4'hF; b3.memWriteData_i = 32'hCAFE0001;
    #1 chk("t4 hold", b3.memHold_o, 1'b1);
    @(negedge clk_i);
    b3.memAddr_i = 32'h20;
    wait_accept(h);
    b3.memEnable_i = 1'b0;
    chk("t4 holds", h, 3);
    access3(1'b0, 32'h10, 4'h0, 32'h0, h);
    chk("t4 rd10", b3.memReadData_o, 32'h0BADF00D);
    access3(1'b0, 32'h20, 4'h0, 32'h0, h);
    chk("t4 rd20", b3.memReadData_o, 32'hCAFE0001);

    // Reset in the middle of a wait aborts the write.
    access3(1'b1, 32'h30, 4'hF, 32'h30303030, h);
    b3.memEnable_i = 1'b1; b3.memIsWrite_i = 1'b1; b3.memAddr_i = 32'h30;
    b3.memWriteData_i = 32'h99999999;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1 chk("t6 rst hold en", b3.memHold_o, 1'b1);
    @(negedge clk_i);
    #1 chk("t6 rst hold en2", b3.memHold_o, 1'b1);
    @(negedge clk_i);
    b3.memEnable_i = 1'b0;
    #1 chk("t6 rst hold idle", b3.memHold_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1 chk("t6 rdata0", b3.memReadData_o, 32'h0);
    @(negedge clk_i);
    access3(1'b0, 32'h30, 4'h0, 32'h0, h);
    chk("t6 holds", h, 3);
    chk("t6 data", b3.memReadData_o, 32'h30303030);

    // Randomised traffic against the reference memory.
    merr = 1'b0;
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      access3(1'b1, 32'(w) << 2, 4'hF, d, h);
      m3[w] = d;
    end
    access3(1'b0, 32'h0, 4'h0, 32'h0, h);
    mrd = m3[0];
    chk("rnd init rd", b3.memReadData_o, mrd);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0)
        a = 32'h400 + (32'($urandom_range(0, 255)) << 2) + 32'($urandom_range(0, 3));
      else
        a = (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
      wr  = 1'($urandom_range(0, 1));
      mk4 = 4'($urandom_range(0, 15));
      d   = $urandom;
      if ($urandom_range(0, 5) == 0) begin
        int n;
        n = $urandom_range(1, 3);
        b3.memEnable_i = 1'b1; b3.memIsWrite_i = wr; b3.memAddr_i = a;
        b3.memWriteMask_i = mk4; b3.memWriteData_i = d;
        for (int k = 0; k < n; k++) begin
          #1 chk($sformatf("r%0d ab hold", i), b3.memHold_o, 1'b1);
          @(negedge clk_i);
        end
        b3.memEnable_i = 1'b0;
        @(negedge clk_i);
      end
      access3(wr, a, mk4, d, h);
      model3(wr, a, mk4, d);
      chk($sformatf("r%0d holds", i), h, 3);
      chk($sformatf("r%0d rdata", i), b3.memReadData_o, mrd);
      chk($sformatf("r%0d err", i), err3, merr);
      if ($urandom_range(0, 4) == 0) begin
        clr3 = 1'b1;
        @(negedge clk_i);
        clr3 = 1'b0;
        merr = 1'b0;
        chk($sformatf("r%0d clr", i), err3, merr);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
